// File: rtl/synch_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// synch_updown_mod_counter
//
// Purpose:
//   Parametrised N-bit up/down modulo counter. It has a count enable, a
//   synchronous parallel load, and flags that let counters be cascaded. It
//   serves as a general event/divider counter. It is also the building block
//   for multi-digit cascaded counters.
//
// Parameters:
//   The counter is N bits wide, with N of at least 1. The count modulus
//   gives the range of Q as 0 up to one less than the modulus. The modulus
//   must be at least 2 and at most 2**N.
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous active-high reset (highest priority)
//   en        in   1  count enable
//   up_dn     in   1  direction: 1 = up, 0 = down
//   load      in   1  synchronous parallel load strobe (beats en)
//   load_val  in   N  value to load; values >= MOD are clamped to MOD-1
//   Q         out  N  current count, registered
//   tc        out  1  terminal count, combinational (for same-edge cascading)
//   wrap      out  1  registered pulse: wrapped (or saturated) on previous edge
//   load_err  out  1  registered pulse: load was clamped on previous edge
//
// Build option:
//   SYNCH_CNT_SATURATE_EN - when defined, an enabled count at a boundary
//   holds the count at that boundary instead of wrapping. wrap then pulses
//   once for each blocked edge. tc, load and load_err behave the same in
//   both builds, and both builds have the same port list.
// ---------------------------------------------------------------------------
module synch_updown_mod_counter #(
    parameter int N   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         wrap,
    output logic         load_err
);

    // Reject illegal parameter combinations at elaboration time.
    generate
        if ((N < 1) || (MOD < 2) || ((N < 31) && (MOD > (2 ** N)))) begin : g_bad_param
            $error("synch_updown_mod_counter: illegal N/MOD combination");
        end
    endgenerate

    // All comparisons are done at N bits. MOD itself may equal 2**N, which
    // does not fit in N bits, so the top count value is used instead.
    localparam logic [N-1:0] MAX_C  = N'(MOD - 1);
    localparam logic [N-1:0] ZERO_C = N'(0);
    localparam logic [N-1:0] ONE_C  = N'(1);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic         wrap_q;
    logic         wrap_d;
    logic         load_err_q;
    logic         load_err_d;

    logic         at_max_s;
    logic         at_zero_s;

    assign at_max_s  = (q_q == MAX_C);
    assign at_zero_s = (q_q == ZERO_C);

    // Next-state logic. Load takes priority over count, and count over hold.
    // Reset is applied in the register block.
    always_comb begin
        q_d        = q_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            // A load never produces a wrap, even when en is high.
            if (load_val > MAX_C) begin
                q_d        = MAX_C;
                load_err_d = 1'b1;
            end else begin
                q_d        = load_val;
                load_err_d = 1'b0;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_max_s) begin
                    wrap_d = 1'b1;
`ifdef SYNCH_CNT_SATURATE_EN
                    q_d    = MAX_C;
`else
                    q_d    = ZERO_C;
`endif
                end else begin
                    q_d = q_q + ONE_C;
                end
            end else begin
                if (at_zero_s) begin
                    wrap_d = 1'b1;
`ifdef SYNCH_CNT_SATURATE_EN
                    q_d    = ZERO_C;
`else
                    q_d    = MAX_C;
`endif
                end else begin
                    q_d = q_q - ONE_C;
                end
            end
        end else begin
            q_d = q_q;
        end
    end

    // State and flag registers with a synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q        <= ZERO_C;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // tc is combinational on purpose. A downstream stage can take this
    // stage's tc as its en and step on the same edge.
    assign tc = en & ~load & ~reset & ((up_dn & at_max_s) | (~up_dn & at_zero_s));

    assign Q        = q_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_synch_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// Testbench for synch_updown_mod_counter.
//
// Two instances share the control inputs:
//   u_a : N=4, MOD=10 (a modulus below the full range)
//   u_b : N=3, MOD=8  (full range, MOD == 2**N)
// A reference model expresses the counting rules with integer modulo
// arithmetic. The model predicts Q, tc, wrap and load_err for each instance.
// ---------------------------------------------------------------------------
module tb_synch_updown_mod_counter;

    localparam int NA = 4;
    localparam int MA = 10;
    localparam int NB = 3;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          up_dn;
    logic          load;
    logic [NA-1:0] lv_a;
    logic [NB-1:0] lv_b;
    logic [NA-1:0] q_a;
    logic [NB-1:0] q_b;
    logic          tc_a, tc_b, wrap_a, wrap_b, err_a, err_b;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: index 0 = u_a, index 1 = u_b.
    int m_q[2];
    int m_wrap[2];
    int m_err[2];
    int mods[2];

    always #5 clk = ~clk;

    synch_updown_mod_counter #(.N(NA), .MOD(MA)) u_a (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv_a), .Q(q_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
    );

    synch_updown_mod_counter #(.N(NB), .MOD(MB)) u_b (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv_b), .Q(q_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // One clock step. Inputs are applied just after a rising edge, and tc is
    // checked before the next edge. The model then advances, and the
    // registered outputs are checked #1 after that edge.
    task automatic step(input bit r, input bit e, input bit u, input bit l, input int v);
        int exp_tc;
        int nq;
        int bnd;
        reset = r; en = e; up_dn = u; load = l;
        lv_a = NA'(v);
        lv_b = NB'(v);
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_tc = (!r && e && !l &&
                      ((u && m_q[k] == mods[k] - 1) || (!u && m_q[k] == 0))) ? 1 : 0;
            chk((k == 0) ? "tc_a" : "tc_b", (k == 0) ? int'(tc_a) : int'(tc_b), exp_tc);
        end
        for (int k = 0; k < 2; k++) begin
            int vk;
            vk = (k == 0) ? (v % 16) : (v % 8);
            if (r) begin
                m_q[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
            end else if (l) begin
                m_wrap[k] = 0;
                if (vk >= mods[k]) begin
                    m_q[k] = mods[k] - 1; m_err[k] = 1;
                end else begin
                    m_q[k] = vk; m_err[k] = 0;
                end
            end else if (e) begin
                m_err[k] = 0;
                bnd = u ? (m_q[k] == mods[k] - 1) : (m_q[k] == 0);
                m_wrap[k] = bnd;
                nq = u ? (m_q[k] + 1) % mods[k] : (m_q[k] + mods[k] - 1) % mods[k];
`ifdef SYNCH_CNT_SATURATE_EN
                if (bnd) nq = m_q[k];
`endif
                m_q[k] = nq;
            end else begin
                m_wrap[k] = 0; m_err[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("q_a",    int'(q_a),    m_q[0]);
        chk("wrap_a", int'(wrap_a), m_wrap[0]);
        chk("err_a",  int'(err_a),  m_err[0]);
        chk("q_b",    int'(q_b),    m_q[1]);
        chk("wrap_b", int'(wrap_b), m_wrap[1]);
        chk("err_b",  int'(err_b),  m_err[1]);
    endtask

    initial begin
        mods[0] = MA; mods[1] = MB;
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
        end
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; lv_a = '0; lv_b = '0;
        @(posedge clk);
        #1;

        // Reset for 2 cycles, then count up for 12 cycles. This covers the
        // wrap at 9 on u_a and the full-range wrap at 7 on u_b.
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 7);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);

        // Load 2, then count down through the wrap at 0.
        step(1'b0, 1'b0, 1'b0, 1'b1, 2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);

        // A clamped load with en high. Then load and reset in the same cycle,
        // where reset must win.
        step(1'b0, 1'b1, 1'b1, 1'b1, 13);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 5);

        // Count up to 6, hold for 3 cycles, then count down twice.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Load 8, then count up across the boundary. In the saturating build
        // this exercises the blocked-edge pulses.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Random stimulus: occasional reset, frequent enable, some loads.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/synch_updown_mod_counter.md
Name: synch_updown_mod_counter

Overview:
- Parametrised successor to the fixed 4-bit synchronous up counter.
- Adds the following over that counter:
  - N-bit width
  - programmable modulus
  - up/down direction
  - count enable
  - synchronous parallel load
  - terminal-count and wrap flags for cascading
- Used as a general event/divider counter in the datapath and as the building block for multi-digit cascaded counters.

Parameters:
- N, 4, counter width in bits; N >= 1.
- MOD, 16, count modulus; range 0..MOD-1. Legal range 2 <= MOD <= 2**N. Illegal values are a compile-time error via generate-time check.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  N  value to load.
- Q  output  N  current count, registered.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse: counter wrapped (or saturated) on the previous edge.
- load_err  output  1  registered one-cycle pulse: rejected/clamped load on the previous edge.

Behaviour:
- Reset values: Q = 0, wrap = 0, load_err = 0. Reset takes effect on the rising edge while reset = 1, regardless of en/load.
- Priority per edge: reset > load > en > hold.
- Load, load_val < MOD: Q <= load_val next edge; load_err <= 0.
- Load, load_val >= MOD: Q <= MOD-1; load_err <= 1 for exactly one cycle.
- Load never asserts wrap, even when en = 1 in the same cycle. Load wins; no count occurs that cycle.
- en = 1, up_dn = 1:
  - Q <= Q+1 if Q < MOD-1.
  - Q <= 0 if Q == MOD-1 (wrap <= 1).
- en = 1, up_dn = 0:
  - Q <= Q-1 if Q > 0.
  - Q <= MOD-1 if Q == 0 (wrap <= 1).
- en = 0 and no load: Q holds; wrap <= 0.
- tc = en & ~load & ~reset & ((up_dn & Q == MOD-1) | (~up_dn & Q == 0)). It is combinational, so a downstream stage's en can be driven by upstream tc for same-edge cascading.
- Latency:
  - Q updates one edge after the control is sampled.
  - wrap/load_err are valid in the cycle following the causing edge and are high for one cycle only.
- MOD == 2**N: wrap arithmetic is the natural N-bit overflow; behaviour is identical to the rules above.
- Direction change mid-count takes effect on the next edge; there is no pipeline to flush.
- Reset asserted mid-count, or in the same cycle as load: reset wins. Q = 0 and both flags clear next edge.
- Internal width: all comparisons are done at N bits.
- up_dn/load_val are ignored when not used.

Optional Feature:
- Macro SYNCH_CNT_SATURATE_EN.
- When defined, the counter saturates instead of wrapping:
  - Up at MOD-1 holds MOD-1.
  - Down at 0 holds 0.
  - wrap asserts for one cycle each time an enabled count is blocked at a boundary (acts as a saturation pulse).
  - tc is unchanged.
  - Load and load_err behaviour are unchanged.
- When not defined: modulo wrap-around exactly as in Behaviour.
- Both builds share the identical port list.

Test Plan:
- Reset/up count: N=4, MOD=10; reset 2 cycles then en=1, up_dn=1 for 12 cycles.
  - Q = 0,1,…,9,0,1.
  - tc high only while Q=9.
  - wrap high one cycle when Q=0 after 9.
- Down wrap: N=4, MOD=10; load 2 then en=1, up_dn=0 for 4 cycles.
  - Q = 2,1,0,9,8.
  - tc high while Q=0.
  - wrap one pulse coincident with Q=9.
- Load clamp/priority: MOD=10; load=1, load_val=13, en=1.
  - Q = 9 next cycle; load_err pulse 1 cycle; wrap = 0.
  - Then load_val=5 with reset=1 in the same cycle gives Q = 0, load_err = 0.
- Enable hold / direction switch: count up to 6, drop en for 3 cycles, then en=1, up_dn=0.
  - Q holds 6 for 3 cycles, then 5,4.
  - tc low throughout.
- Full-range: N=3, MOD=8; up 10 cycles from 0.
  - Q = 0..7,0,1,2.
  - wrap once after 7.
- SYNCH_CNT_SATURATE_EN build: MOD=10; up from 8 for 4 cycles.
  - Q = 9,9,9,9.
  - wrap pulses on each blocked edge.
  - Down from 1 gives 0,0 with wrap pulsing.
